// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
//   Shared types for the execution unit's divide path.
//   - div_state_e     : states of the multi-cycle restoring divider
//   - alu_operation_e : ALU operation codes; the sequencer maps ALU_OP_DIV and
//                       ALU_OP_DIVU onto the divider's start/signed_op inputs
//   - WORD_BITS/BYTE_BITS : quotient widths for word (32/16) and byte (16/8) divides
// -----------------------------------------------------------------------------
package divider_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIXUP,
        WAIT,
        DONE
    } div_state_e;

    typedef enum logic [3:0] {
        ALU_OP_ADD,
        ALU_OP_SUB,
        ALU_OP_AND,
        ALU_OP_OR,
        ALU_OP_XOR,
        ALU_OP_MUL,
        ALU_OP_MULU,
        ALU_OP_DIV,
        ALU_OP_DIVU
    } alu_operation_e;

    localparam int unsigned WORD_BITS = 16;
    localparam int unsigned BYTE_BITS = 8;

endpackage

// File: rtl/divider_if.sv
// -----------------------------------------------------------------------------
// divider_if
//   Request/result bundle between the sequencer (master) and the divider (slave).
//   Request : start, signed_op, wide, dividend[31:0], divisor[15:0]
//   Result  : busy, done, div_error, quotient[15:0], remainder[15:0]
// -----------------------------------------------------------------------------
interface divider_if;
    import divider_pkg::*;

    logic        start;
    logic        signed_op;
    logic        wide;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic        div_error;
    logic [15:0] quotient;
    logic [15:0] remainder;

    modport master (
        output start, signed_op, wide, dividend, divisor,
        input  busy, done, div_error, quotient, remainder
    );

    modport slave (
        input  start, signed_op, wide, dividend, divisor,
        output busy, done, div_error, quotient, remainder
    );

endinterface

// File: rtl/divider.sv
// -----------------------------------------------------------------------------
// divider
//   Multi-cycle restoring divider for V30 DIVU/DIV, byte (16/8) and word (32/16).
//   The divide runs on magnitudes; signs are re-applied in FIXUP. A divide
//   exception (zero divisor or quotient out of range) is reported on div_error
//   together with done, leaving quotient/remainder at their previous values.
//   Ports:
//     clk    : core clock, rising edge
//     reset  : synchronous, active-high
//     bus    : divider_if.slave (start, signed_op, wide, dividend, divisor ->
//              busy, done, div_error, quotient, remainder)
//   Parameter:
//     EXTRA_CYCLES : wait cycles inserted between FIXUP and DONE
// -----------------------------------------------------------------------------
module divider
    import divider_pkg::*;
#(
    parameter int unsigned EXTRA_CYCLES = 0
) (
    input  logic     clk,
    input  logic     reset,
    divider_if.slave bus
);

    localparam int unsigned WAIT_W = (EXTRA_CYCLES > 1) ? $clog2(EXTRA_CYCLES + 1) : 1;

    function automatic logic [7:0] neg8(input logic [7:0] x);
        return ~x + 8'd1;
    endfunction

    function automatic logic [15:0] neg16(input logic [15:0] x);
        return ~x + 16'd1;
    endfunction

    function automatic logic [31:0] neg32(input logic [31:0] x);
        return ~x + 32'd1;
    endfunction

    div_state_e        state_q, state_d;

    // Operands latched on acceptance
    logic [31:0]       dvd_q;
    logic [15:0]       dvs_q;
    logic              signed_q;
    logic              wide_q;

    // Iteration state
    logic [15:0]       r_q;
    logic [15:0]       q_q;
    logic [15:0]       dvs_mag_q;
    logic              quo_neg_q;
    logic              rem_neg_q;
    logic [4:0]        cnt_q;
    logic [WAIT_W-1:0] wait_q;

    // Results held across the optional WAIT padding
    logic [15:0]       pend_quo_q;
    logic [15:0]       pend_rem_q;
    logic              pend_err_q;

    // Visible results
    logic [15:0]       quo_q;
    logic [15:0]       rem_q;
    logic              err_q;

    // PREP: operand magnitudes and the early overflow test
    logic              dvd_neg, dvs_neg;
    logic [31:0]       dvd_mag;
    logic [15:0]       dvs_mag, mag_hi, mag_lo;
    logic              prep_err;

    always_comb begin
        dvd_neg = signed_q & (wide_q ? dvd_q[31] : dvd_q[15]);
        dvs_neg = signed_q & (wide_q ? dvs_q[15] : dvs_q[7]);
        if (wide_q) begin
            dvd_mag = dvd_neg ? neg32(dvd_q) : dvd_q;
            dvs_mag = dvs_neg ? neg16(dvs_q) : dvs_q;
            mag_hi  = dvd_mag[31:16];
            mag_lo  = dvd_mag[15:0];
        end else begin
            dvd_mag = {16'h0, (dvd_neg ? neg16(dvd_q[15:0]) : dvd_q[15:0])};
            dvs_mag = {8'h0, (dvs_neg ? neg8(dvs_q[7:0]) : dvs_q[7:0])};
            mag_hi  = {8'h0, dvd_mag[15:8]};
            mag_lo  = {8'h0, dvd_mag[7:0]};
        end
        // A high half at or above the divisor cannot give an N-bit quotient.
        prep_err = (dvs_mag == 16'h0) || (mag_hi >= dvs_mag);
    end

    // ITER: one restoring step. R stays below the divisor, so the shifted
    // value fits N+1 bits and bit 16 of the difference is the borrow.
    logic [16:0]       r_sh, r_diff;
    logic              r_ge;

    always_comb begin
        r_sh   = {r_q, (wide_q ? q_q[15] : q_q[7])};
        r_diff = r_sh - {1'b0, dvs_mag_q};
        r_ge   = ~r_diff[16];
    end

    // FIXUP: re-apply signs and check the signed quotient range
    logic [15:0]       q_mag, q_half, q_signed, r_signed, quo_res, rem_res;
    logic              fix_err;

    always_comb begin
        q_mag    = wide_q ? q_q : {8'h0, q_q[7:0]};
        q_half   = wide_q ? 16'h8000 : 16'h0080;
        q_signed = quo_neg_q ? neg16(q_mag) : q_mag;
        r_signed = rem_neg_q ? neg16(r_q) : r_q;
        quo_res  = wide_q ? q_signed : {8'h0, q_signed[7:0]};
        rem_res  = wide_q ? r_signed : {8'h0, r_signed[7:0]};
        // Negative results may reach -2^(N-1); positive ones stop at 2^(N-1)-1.
        fix_err  = signed_q && (quo_neg_q ? (q_mag > q_half) : (q_mag >= q_half));
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = PREP;
            PREP:    state_d = prep_err ? DONE : ITER;
            ITER:    if (cnt_q == 5'd1) state_d = FIXUP;
            FIXUP:   state_d = (EXTRA_CYCLES > 0) ? WAIT : DONE;
            WAIT:    if (wait_q == WAIT_W'(1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.busy      = (state_q != IDLE);
        bus.done      = (state_q == DONE);
        bus.div_error = err_q;
        bus.quotient  = quo_q;
        bus.remainder = rem_q;
    end

    // Datapath registers (no reset: always loaded before use)
    always_ff @(posedge clk) begin
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dvd_q    <= bus.dividend;
                    dvs_q    <= bus.divisor;
                    signed_q <= bus.signed_op;
                    wide_q   <= bus.wide;
                end
            end
            PREP: begin
                r_q       <= mag_hi;
                q_q       <= mag_lo;
                dvs_mag_q <= dvs_mag;
                quo_neg_q <= dvd_neg ^ dvs_neg;
                rem_neg_q <= dvd_neg;
                cnt_q     <= 5'(wide_q ? WORD_BITS : BYTE_BITS);
            end
            ITER: begin
                r_q   <= r_ge ? r_diff[15:0] : r_sh[15:0];
                q_q   <= {q_q[14:0], r_ge};
                cnt_q <= cnt_q - 5'd1;
            end
            FIXUP: begin
                pend_quo_q <= quo_res;
                pend_rem_q <= rem_res;
                pend_err_q <= fix_err;
                wait_q     <= WAIT_W'(EXTRA_CYCLES);
            end
            WAIT: begin
                wait_q <= wait_q - WAIT_W'(1);
            end
            default: ;
        endcase
    end

    // Result registers update only on entry to DONE; an error leaves the
    // previous quotient/remainder in place.
    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q <= 16'h0;
            rem_q <= 16'h0;
            err_q <= 1'b0;
        end else if (state_d == DONE) begin
            case (state_q)
                PREP: begin
                    err_q <= 1'b1;
                end
                FIXUP: begin
                    err_q <= fix_err;
                    if (!fix_err) begin
                        quo_q <= quo_res;
                        rem_q <= rem_res;
                    end
                end
                WAIT: begin
                    err_q <= pend_err_q;
                    if (!pend_err_q) begin
                        quo_q <= pend_quo_q;
                        rem_q <= pend_rem_q;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// -----------------------------------------------------------------------------
// tb_divider
//   Self-checking bench for divider: a table of directed divides with
//   hand-computed quotient/remainder/error/latency, followed by hand-written
//   sequences for start-while-busy, start in the DONE cycle and mid-divide reset.
// -----------------------------------------------------------------------------
module tb_divider;

    logic clk = 1'b0;
    logic reset;

    divider_if bus ();

    divider #(.EXTRA_CYCLES(0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic        w;
        logic [31:0] dvd;
        logic [15:0] dvs;
        logic [15:0] q;
        logic [15:0] r;
        logic        err;
        int          cyc;
    } vec_t;

    vec_t vecs [14];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one divide from an IDLE cycle; returns the cycle index of done
    // (acceptance cycle = 0) or -1 if done never arrived.
    task automatic run_div(input logic s, input logic w, input logic [31:0] dvd,
                           input logic [15:0] dvs, output int cyc, output logic busy1);
        @(posedge clk);
        @(negedge clk);
        bus.signed_op = s;
        bus.wide      = w;
        bus.dividend  = dvd;
        bus.divisor   = dvs;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        // Scramble the inputs: the divider must work from its latched copy.
        bus.dividend = ~dvd;
        bus.divisor  = ~dvs;
        bus.wide     = ~w;
        busy1        = bus.busy;
        cyc          = 1;
        while (!bus.done && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!bus.done) cyc = -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        logic busy1;
        int   n_done, first_c, second_c;
        logic [15:0] first_q, second_q;

        vecs[0]  = '{1'b0, 1'b1, 32'h0001_0005, 16'h0002, 16'h8002, 16'h0001, 1'b0, 19};
        vecs[1]  = '{1'b0, 1'b0, 32'h0000_0064, 16'h0007, 16'h000E, 16'h0002, 1'b0, 11};
        vecs[2]  = '{1'b1, 1'b1, 32'hFFFF_FFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 19};
        vecs[3]  = '{1'b1, 1'b0, 32'hDEAD_FF80, 16'hAB01, 16'h0080, 16'h0000, 1'b0, 11};
        vecs[4]  = '{1'b0, 1'b1, 32'h1234_5678, 16'h0000, 16'h0080, 16'h0000, 1'b1, 2};
        vecs[5]  = '{1'b0, 1'b1, 32'h0002_0000, 16'h0002, 16'h0080, 16'h0000, 1'b1, 2};
        vecs[6]  = '{1'b1, 1'b1, 32'h0000_8000, 16'h0001, 16'h0080, 16'h0000, 1'b1, 19};
        vecs[7]  = '{1'b1, 1'b1, 32'hFFFF_8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 19};
        vecs[8]  = '{1'b1, 1'b1, 32'hFFFF_8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b1, 19};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0080, 16'h0001, 16'h8000, 16'h0000, 1'b1, 11};
        vecs[10] = '{1'b1, 1'b0, 32'h0000_FF9C, 16'h0007, 16'h00F2, 16'h00FE, 1'b0, 11};
        vecs[11] = '{1'b1, 1'b1, 32'h0000_03E8, 16'hFFF9, 16'hFF72, 16'h0006, 1'b0, 19};
        vecs[12] = '{1'b0, 1'b0, 32'h0000_FEFF, 16'h00FF, 16'h00FF, 16'h00FE, 1'b0, 11};
        vecs[13] = '{1'b1, 1'b0, 32'h0000_0040, 16'h0080, 16'h0000, 16'h0040, 1'b0, 11};

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.signed_op = 1'b0;
        bus.wide      = 1'b0;
        bus.dividend  = 32'h0;
        bus.divisor   = 16'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("reset_busy", 32'(bus.busy), 32'h0);
        check("reset_done", 32'(bus.done), 32'h0);
        check("reset_err",  32'(bus.div_error), 32'h0);
        check("reset_q",    32'(bus.quotient), 32'h0);
        check("reset_r",    32'(bus.remainder), 32'h0);

        for (int i = 0; i < 14; i++) begin
            run_div(vecs[i].s, vecs[i].w, vecs[i].dvd, vecs[i].dvs, cyc, busy1);
            check($sformatf("v%0d_cycle", i), 32'(cyc), 32'(vecs[i].cyc));
            check($sformatf("v%0d_busy", i), 32'(busy1), 32'h1);
            check($sformatf("v%0d_err", i), 32'(bus.div_error), 32'(vecs[i].err));
            check($sformatf("v%0d_q", i), 32'(bus.quotient), 32'(vecs[i].q));
            check($sformatf("v%0d_r", i), 32'(bus.remainder), 32'(vecs[i].r));
        end

        // start held high: ignored while busy and in DONE, re-accepted in IDLE.
        // Operands switch to a byte divide mid-way; only the second divide sees them.
        @(posedge clk);
        @(negedge clk);
        bus.signed_op = 1'b0;
        bus.wide      = 1'b1;
        bus.dividend  = 32'h0001_0005;
        bus.divisor   = 16'h0002;
        bus.start     = 1'b1;
        n_done   = 0;
        first_c  = -1;
        second_c = -1;
        first_q  = 16'h0;
        second_q = 16'h0;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                n_done++;
                if (n_done == 1) begin
                    first_c = c;
                    first_q = bus.quotient;
                end else if (n_done == 2) begin
                    second_c = c;
                    second_q = bus.quotient;
                end
            end
            if (c == 5) begin
                bus.wide     = 1'b0;
                bus.dividend = 32'h0000_0064;
                bus.divisor  = 16'h0007;
            end
            if (c == 31) bus.start = 1'b0;
        end
        check("hold_done_count", 32'(n_done), 32'd2);
        check("hold_first_cycle", 32'(first_c), 32'd19);
        check("hold_first_q", 32'(first_q), 32'h8002);
        check("hold_second_cycle", 32'(second_c), 32'd31);
        check("hold_second_q", 32'(second_q), 32'h000E);

        // Reset in cycle 7 of a word divide
        @(posedge clk);
        @(negedge clk);
        bus.signed_op = 1'b0;
        bus.wide      = 1'b1;
        bus.dividend  = 32'h0001_0005;
        bus.divisor   = 16'h0002;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int c = 2; c <= 7; c++) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_done", 32'(bus.done), 32'h0);
        check("abort_err",  32'(bus.div_error), 32'h0);
        check("abort_q",    32'(bus.quotient), 32'h0);
        check("abort_r",    32'(bus.remainder), 32'h0);
        n_done = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'h0);

        run_div(1'b0, 1'b1, 32'h0001_0005, 16'h0002, cyc, busy1);
        check("post_reset_cycle", 32'(cyc), 32'd19);
        check("post_reset_q", 32'(bus.quotient), 32'h8002);
        check("post_reset_r", 32'(bus.remainder), 32'h0001);

        // done must drop after its single cycle
        @(posedge clk);
        #1;
        check("done_pulse_width", 32'(bus.done), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
